// File: rtl/hazard_stall_controller.sv
// Pipeline sequencer for the 5-stage MIPS core: stall/flush/advance control for
// load-use and RAW hazards, taken branches and multi-cycle mult/div, plus a stall counter.
module hazard_stall_controller #(
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             forwarding,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_store,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [4:0]       ex_rd,
    input  logic             mem_reg_write,
    input  logic [4:0]       mem_rd,
    input  logic             ex_branch_taken,
    input  logic             ex_md_start,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_bubble,
    output logic             md_done,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] CNT_LOAD = 4'(MD_LATENCY - 2);

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_q;
    logic             md_stall;
    logic             ex_hit, mem_hit, load_use, raw, hazard;

    // BUSY lasts exactly CNT_LOAD cycles: leave as the count reaches zero, so the
    // IDLE start cycle plus BUSY gives MD_LATENCY-1 held cycles before DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (ex_md_start) begin
                    cnt_d   = CNT_LOAD;
                    state_d = (CNT_LOAD == 4'd0) ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign md_stall = !reset && (((state_q == S_IDLE) && ex_md_start) || (state_q == S_BUSY));
    assign md_busy  = md_stall;

    assign ex_hit  = (ex_rd != 5'd0)
                  && ((id_uses_rs && (ex_rd == id_rs)) || (id_uses_rt && (ex_rd == id_rt)));
    assign mem_hit = (mem_rd != 5'd0)
                  && ((id_uses_rs && (mem_rd == id_rs)) || (id_uses_rt && (mem_rd == id_rt)));

    // Store data on rt is forwarded into MEM, so a SW behind a load only stalls on rs.
    assign load_use = forwarding && ex_mem_read && (ex_rd != 5'd0)
                   && ((id_uses_rs && (ex_rd == id_rs))
                       || (id_uses_rt && (ex_rd == id_rt) && !id_is_store));
    assign raw      = !forwarding && ((ex_reg_write && ex_hit) || (mem_reg_write && mem_hit));
    assign hazard   = load_use || raw;

    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_flush   = 1'b0;
        exmem_bubble = 1'b0;
        md_done      = !reset && (state_q == S_DONE);
        if (reset) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (md_stall) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (hazard) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (!pc_en && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_count = stall_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller: expected control vectors are queued
// as each cycle's stimulus is driven and compared when the outputs settle.
module tb_hazard_stall_controller;

    localparam int unsigned LAT = 4;
    localparam int unsigned CW  = 4;

    logic          clk = 1'b0;
    logic          reset, forwarding;
    logic [4:0]    id_rs, id_rt, ex_rd, mem_rd;
    logic          id_uses_rs, id_uses_rt, id_is_store;
    logic          ex_mem_read, ex_reg_write, mem_reg_write;
    logic          ex_branch_taken, ex_md_start;
    logic          pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic          exmem_bubble, md_done, md_busy;
    logic [CW-1:0] stall_count;

    always #5 clk = ~clk;

    hazard_stall_controller #(.MD_LATENCY(LAT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .forwarding(forwarding),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_is_store(id_is_store), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_rd(ex_rd), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .ex_branch_taken(ex_branch_taken), .ex_md_start(ex_md_start),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_flush(idex_flush), .exmem_bubble(exmem_bubble), .md_done(md_done),
        .md_busy(md_busy), .stall_count(stall_count)
    );

    typedef struct {
        string         tag;
        logic [7:0]    ctl;   // {pc,ifid_en,ifid_fl,idex_en,idex_fl,bubble,done,busy}
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    int unsigned m_left = 0;
    bit          m_done = 1'b0;
    int unsigned m_cnt  = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply(input string tag, input bit rst, input bit fwd,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input bit urs, input bit urt, input bit st,
                         input bit mr, input bit ewr, input logic [4:0] erd,
                         input bit mwr, input logic [4:0] mrd,
                         input bit br, input bit ms);
        exp_t e, got;
        bit   stall, lu, rw, ehit, mhit;
        reset = rst;           forwarding = fwd;
        id_rs = rs;            id_rt = rt;
        id_uses_rs = urs;      id_uses_rt = urt;      id_is_store = st;
        ex_mem_read = mr;      ex_reg_write = ewr;    ex_rd = erd;
        mem_reg_write = mwr;   mem_rd = mrd;
        ex_branch_taken = br;  ex_md_start = ms;

        stall = !m_done && ((m_left == 0 && ms) || m_left > 0);
        ehit  = (erd != 0) && ((urs && erd == rs) || (urt && erd == rt));
        mhit  = (mrd != 0) && ((urs && mrd == rs) || (urt && mrd == rt));
        lu    = fwd && mr && (erd != 0) && ((urs && erd == rs) || (urt && erd == rt && !st));
        rw    = !fwd && ((ewr && ehit) || (mwr && mhit));
        e.tag = tag;
        if (rst)             e.ctl = 8'b0010_1000;
        else if (stall)      e.ctl = 8'b0000_0101;
        else if (br)         e.ctl = {7'b1111_100, 1'b0} | {6'b0, m_done, 1'b0};
        else if (lu || rw)   e.ctl = {7'b0001_100, 1'b0} | {6'b0, m_done, 1'b0};
        else                 e.ctl = {7'b1101_000, 1'b0} | {6'b0, m_done, 1'b0};
        e.cnt = rst ? '0 : CW'(m_cnt);
        sb.push_back(e);

        #2;
        got.ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_bubble, md_done, md_busy};
        got.cnt = stall_count;
        e = sb.pop_front();
        check_val({e.tag, "/ctl"}, 32'(got.ctl), 32'(e.ctl));
        check_val({e.tag, "/cnt"}, 32'(got.cnt), 32'(e.cnt));

        @(posedge clk);
        #1;
        if (rst) m_cnt = 0;
        else if (!e.ctl[7] && m_cnt < (1 << CW) - 1) m_cnt++;
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_done = 1'b1;
        end else if (ms) begin
            m_left = LAT - 2;
            if (m_left == 0) m_done = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b1; forwarding = 1'b1; id_rs = '0; id_rt = '0; ex_rd = '0; mem_rd = '0;
        id_uses_rs = 0; id_uses_rt = 0; id_is_store = 0; ex_mem_read = 0; ex_reg_write = 0;
        mem_reg_write = 0; ex_branch_taken = 0; ex_md_start = 0;
        @(posedge clk);
        #1;
        //         tag          rst fwd rs rt urs urt st mr ewr erd mwr mrd br ms
        apply("reset",      1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply("idle",       0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply("t1_lu",      0, 1, 5, 0, 1, 0, 0, 1, 1, 5, 0, 0, 0, 0);
        apply("t1_go",      0, 1, 5, 0, 1, 0, 0, 0, 1, 5, 0, 0, 0, 0);
        apply("t2_sw_rt",   0, 1, 0, 5, 0, 1, 1, 1, 1, 5, 0, 0, 0, 0);
        apply("t2_sw_rs",   0, 1, 5, 5, 1, 1, 1, 1, 1, 5, 0, 0, 0, 0);
        apply("t3_mem_rt",  0, 0, 0, 7, 0, 1, 0, 0, 0, 0, 1, 7, 0, 0);
        apply("t3_r0",      0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        apply("t3_ex_rs",   0, 0, 9, 0, 1, 0, 0, 0, 1, 9, 0, 0, 0, 0);
        apply("t3_wb_fwd",  0, 1, 7, 0, 1, 0, 0, 0, 1, 7, 1, 7, 0, 0);
        apply("t5_br_lu",   0, 1, 5, 0, 1, 0, 0, 1, 1, 5, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++)
            apply($sformatf("t4_md%0d", i), 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        apply("t4_after",   0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            apply($sformatf("t5_mdbr%0d", i), 0, 1, 5, 0, 1, 0, 0, 1, 1, 5, 0, 0, 1, 1);
        apply("t5_done_br", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        apply("t5_after",   0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply("t6_md0",     0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        apply("t6_md1",     0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        apply("t6_rst",     1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++)
            apply($sformatf("t6_re%0d", i), 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        apply("t6_after",   0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++)
            apply($sformatf("sat%0d", i), 0, 0, 3, 0, 1, 0, 0, 0, 0, 0, 1, 3, 0, 0);
        apply("sat_end",    0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_val("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
